// File: rtl/mux8to1_tdm.sv
// mux8to1_tdm: 8-channel time-division multiplexer (transmit side).
// Captures eight W-bit channel words into a shadow register on an accepted
// load and sends them one slot at a time on Y, with the slot index on S so
// the far-end demux can steer each word back to its channel. Each slot is
// held for HOLD cycles; a new frame can be accepted during the last cycle of
// the current one so consecutive frames run without a gap.
module mux8to1_tdm #(
    parameter int W    = 1,
    parameter int HOLD = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [8*W-1:0] D,
    input  logic           load,
    output logic           ready,
    output logic [W-1:0]   Y,
    output logic [2:0]     S,
    output logic           valid,
    output logic           done
);

    localparam int HC_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [8*W-1:0]  shadow;
    logic [8*W-1:0]  shadow_nx;
    logic [2:0]      slot;
    logic [2:0]      slot_nx;
    logic [HC_W-1:0] hold_cnt;
    logic [HC_W-1:0] hold_nx;
    logic            slot_end;
    logic            last;
    logic            accept;
    logic [W-1:0]    lane;

    // Frame boundary and handshake, all decoded from registered state only.
    assign slot_end = (hold_cnt == HOLD_LAST);
    assign last     = (state == SEND) && (slot == 3'd7) && slot_end;
    assign ready    = (state == IDLE) || last;
    assign accept   = load && ready;

    // State register; reset drops any frame in flight at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shadow   <= '0;
            slot     <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nx;
            shadow   <= shadow_nx;
            slot     <= slot_nx;
            hold_cnt <= hold_nx;
        end
    end

    // Next-state: capture on accept, walk hold_cnt then slot, chain or return to IDLE at the end.
    always_comb begin
        state_nx  = state;
        shadow_nx = shadow;
        slot_nx   = slot;
        hold_nx   = hold_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx  = SEND;
                    shadow_nx = D;
                    slot_nx   = '0;
                    hold_nx   = '0;
                end
            end
            SEND: begin
                if (last) begin
                    slot_nx = '0;
                    hold_nx = '0;
                    if (accept) begin
                        shadow_nx = D;
                    end else begin
                        state_nx = IDLE;
                    end
                end else if (slot_end) begin
                    slot_nx = slot + 3'd1;
                    hold_nx = '0;
                end else begin
                    hold_nx = hold_cnt + HC_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Pick the shadow word for the current slot.
    always_comb begin
        lane = '0;
        for (int k = 0; k < 8; k++) begin
            if (slot == 3'(k)) begin
                lane = shadow[k*W +: W];
            end
        end
    end

    // Outputs are forced to zero while idle so stale shadow data never leaks.
    always_comb begin
        valid = (state == SEND);
        Y     = valid ? lane : '0;
        S     = valid ? slot : 3'd0;
        done  = last;
    end

endmodule

// File: tb/tb_mux8to1_tdm.sv
// tb_mux8to1_tdm: scoreboard bench for mux8to1_tdm.
// Two instances (W=1/HOLD=1 and W=4/HOLD=3) share load and data. On every
// accepted load the reference model expands the captured word into the full
// list of per-cycle slot expectations; a negedge monitor pops one entry per
// cycle and compares, and a far-end demux model reassembles each frame.
module tb_mux8to1_tdm;

    typedef struct packed {
        logic [3:0] y;
        logic [2:0] s;
        logic       done;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [31:0] d_bus;

    logic [0:0]  y0;
    logic [3:0]  y1;
    logic [2:0]  s0, s1;
    logic        valid0, valid1, done0, done1, ready0, ready1;

    logic [3:0]  y_o [2];
    logic [2:0]  s_o [2];
    logic        v_o [2];
    logic        d_o [2];
    logic        r_o [2];

    exp_t        sbq  [2][$];
    logic [31:0] fwq  [2][$];
    logic [31:0] asm_w [2];

    int n_cmp;
    int n_fail;

    mux8to1_tdm #(.W(1), .HOLD(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .D(d_bus[7:0]), .load(load),
        .ready(ready0), .Y(y0), .S(s0), .valid(valid0), .done(done0)
    );

    mux8to1_tdm #(.W(4), .HOLD(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .D(d_bus), .load(load),
        .ready(ready1), .Y(y1), .S(s1), .valid(valid1), .done(done1)
    );

    assign y_o[0] = {3'b000, y0};
    assign y_o[1] = y1;
    assign s_o[0] = s0;
    assign s_o[1] = s1;
    assign v_o[0] = valid0;
    assign v_o[1] = valid1;
    assign d_o[0] = done0;
    assign d_o[1] = done1;
    assign r_o[0] = ready0;
    assign r_o[1] = ready1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int w_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic int hold_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, i, $time, act, exp);
        end
    endtask

    // Expand one captured frame into its per-cycle expectations.
    task automatic push_frame(input int i, input logic [31:0] d);
        int          w;
        int          hold;
        logic [31:0] word;
        exp_t        e;
        w    = w_of(i);
        hold = hold_of(i);
        word = (i == 0) ? {24'd0, d[7:0]} : d;
        for (int s = 0; s < 8; s++) begin
            for (int h = 0; h < hold; h++) begin
                e.y    = 4'((word >> (s * w)) & ((32'd1 << w) - 32'd1));
                e.s    = 3'(s);
                e.done = (s == 7) && (h == hold - 1);
                sbq[i].push_back(e);
            end
        end
        fwq[i].push_back(word);
    endtask

    // Expected status vector {valid, S, Y, done, ready}
    function automatic logic [31:0] pack_obs(input logic v, input logic [2:0] s,
                                             input logic [3:0] y, input logic dn, input logic r);
        return {22'd0, v, s, y, dn, r};
    endfunction

    task automatic check_reset_outputs();
        for (int i = 0; i < 2; i++) begin
            check("reset_outputs", i, pack_obs(v_o[i], s_o[i], y_o[i], d_o[i], r_o[i]),
                  pack_obs(1'b0, 3'd0, 4'd0, 1'b0, 1'b1));
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            sbq[i].delete();
            fwq[i].delete();
            asm_w[i] = '0;
        end
    endtask

    // Model side of the handshake: a load is taken when no frame cycles remain after this one.
    initial begin
        forever begin
            @(posedge clk);
            if (rst_n && load) begin
                for (int i = 0; i < 2; i++) begin
                    if (sbq[i].size() == 0) push_frame(i, d_bus);
                end
            end
        end
    end

    // Monitor: one expectation per cycle per instance, plus far-end reassembly.
    initial begin
        exp_t        e;
        logic        exr;
        logic [31:0] expv;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int i = 0; i < 2; i++) begin
                    if (sbq[i].size() > 0) begin
                        exr  = (sbq[i].size() == 1);
                        e    = sbq[i].pop_front();
                        expv = pack_obs(1'b1, e.s, e.y, e.done, exr);
                    end else begin
                        expv = pack_obs(1'b0, 3'd0, 4'd0, 1'b0, 1'b1);
                    end
                    check("slot", i, pack_obs(v_o[i], s_o[i], y_o[i], d_o[i], r_o[i]), expv);
                    if (v_o[i]) begin
                        for (int b = 0; b < w_of(i); b++) begin
                            asm_w[i][int'(s_o[i]) * w_of(i) + b] = y_o[i][b];
                        end
                    end
                    if (d_o[i] && fwq[i].size() > 0) begin
                        check("reassemble", i, asm_w[i], fwq[i].pop_front());
                    end
                end
            end
        end
    end

    task automatic cycle(input logic l, input logic [31:0] d);
        @(posedge clk);
        #1;
        load  = l;
        d_bus = d;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((sbq[0].size() != 0 || sbq[1].size() != 0) && guard < 200) begin
            cycle(1'b0, $urandom);
            guard++;
        end
        if (sbq[0].size() != 0 || sbq[1].size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL idle_timeout: frames still pending %0d/%0d, required 0/0", sbq[0].size(), sbq[1].size());
        end
        cycle(1'b0, $urandom);
        cycle(1'b0, $urandom);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required finish before 1000000");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        load   = 1'b0;
        d_bus  = '0;
        rst_n  = 1'b0;
        clear_model();
        #2;
        check_reset_outputs();
        cycle(1'b0, 32'd0);
        rst_n = 1'b1;
        cycle(1'b0, 32'd0);

        // Single frames with the example patterns
        cycle(1'b1, 32'h0000_00B2);
        cycle(1'b0, 32'h0000_0000);
        wait_idle();
        cycle(1'b1, 32'h0000_00A5);
        cycle(1'b0, 32'hFFFF_FFFF);
        wait_idle();
        cycle(1'b1, 32'h7654_3210);
        cycle(1'b0, 32'h0000_0000);
        wait_idle();

        // Back-to-back: load held high across frame boundaries
        cycle(1'b1, 32'hFFFF_FFFF);
        for (int k = 0; k < 40; k++) cycle(1'b1, 32'h0000_0000);
        cycle(1'b0, 32'h0000_0000);
        wait_idle();

        // Load while busy is ignored and data changes do not affect the frame
        cycle(1'b1, 32'h0000_000F);
        for (int k = 0; k < 3; k++) cycle(1'b0, 32'h0000_000F);
        cycle(1'b1, 32'h0000_00F0);
        cycle(1'b0, 32'h0000_00AB);
        wait_idle();

        // Reset in the middle of a frame
        cycle(1'b1, 32'h1234_5678);
        for (int k = 0; k < 5; k++) cycle(1'b0, 32'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        clear_model();
        #1;
        check_reset_outputs();
        cycle(1'b0, 32'h0);
        check_reset_outputs();
        rst_n = 1'b1;
        cycle(1'b0, 32'h0);
        cycle(1'b1, 32'h0000_0081);
        cycle(1'b0, 32'h0);
        wait_idle();

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(0, 2) == 0, $urandom);
        end
        cycle(1'b0, 32'h0);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
